mmio_bridge: RTL and testbench

Parametrised memory-mapped I/O bridge between the SLC-3 CPU's MAR/MDR interface and board resources: external SRAM, switches, hex digit register and LED register. Replaces the fixed single-cycle Mem2IO path with a request/ready handshake and configurable SRAM wait states, a configurable hex digit count, and a readable/writable LED register. Sits between the datapath/ISDU and the top-level board pins. The ISDU waits on `cpu_ready` instead of fixed memory states.

---
 rtl/mmio_bridge_pkg.sv | 13 +
 rtl/mmio_bridge_io_regs.sv | 61 ++++++
 rtl/mmio_bridge.sv | 123 ++++++++++++
 tb/tb_mmio_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bridge_pkg.sv
// Shared types and constants for the MMIO bridge: FSM state encoding and I/O register offsets.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SRAM = 2'd1,
    RESP = 2'd2
  } mmio_state_t;

  localparam int IO_OFS_SW_HEX = 0;
  localparam int IO_OFS_LED    = 1;

endpackage

// File: rtl/mmio_bridge_io_regs.sv
// Board I/O register bank: hex digit and LED registers, plus the read mux over switches/LED.
module mmio_io_regs
  import mmio_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int SW_W   = 16,
  parameter int N_HEX  = 4
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   ofs,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [SW_W-1:0]     switches,
  output logic [DATA_W-1:0]   rdata,
  output logic [N_HEX*4-1:0]  hex_digits,
  output logic [DATA_W-1:0]   led
);

  logic              sel_hex;
  logic              sel_led;
  logic [DATA_W-1:0] led_reg;

  assign sel_hex = (ofs == ADDR_W'(IO_OFS_SW_HEX));
  assign sel_led = (ofs == ADDR_W'(IO_OFS_LED));

  // One nibble register per displayed digit; only the low N_HEX digits of wdata are kept.
  for (genvar gi = 0; gi < N_HEX; gi++) begin : g_digit
    logic [3:0] digit_reg;
    always_ff @(posedge clk) begin
      if (srst) begin
        digit_reg <= '0;
      end else if (wr && sel_hex) begin
        digit_reg <= wdata[4*gi +: 4];
      end
    end
    assign hex_digits[4*gi +: 4] = digit_reg;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      led_reg <= '0;
    end else if (wr && sel_led) begin
      led_reg <= wdata;
    end
  end

  assign led = led_reg;

  // Unmapped offsets read as zero.
  always_comb begin
    rdata = '0;
    if (sel_hex) begin
      rdata[SW_W-1:0] = switches;
    end else if (sel_led) begin
      rdata = led_reg;
    end
  end

endmodule

// File: rtl/mmio_bridge.sv
// MAR/MDR to board-resource bridge: request/ready handshake, SRAM access with wait states,
// and single-cycle I/O registers above IO_BASE. All outputs are registered.
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                SW_W      = 16,
  parameter int                N_HEX     = 4,
  parameter int                SRAM_WAIT = 1,
  parameter logic [ADDR_W-1:0] IO_BASE   = 16'hFFFE
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                busy,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                sram_oe,
  output logic                sram_we,
  input  logic [SW_W-1:0]     switches,
  output logic [N_HEX*4-1:0]  hex_digits,
  output logic [DATA_W-1:0]   led
);

  localparam int CNT_W = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;

  mmio_state_t       state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              ready_reg, busy_reg, oe_reg, wstb_reg;

  logic              accept, is_io, io_wr, we_next;
  logic [ADDR_W-1:0] io_ofs;
  logic [DATA_W-1:0] io_rdata;

  assign accept  = (state_reg == IDLE) && cpu_req;
  assign is_io   = (cpu_addr >= IO_BASE);
  assign io_ofs  = cpu_addr - IO_BASE;
  assign io_wr   = accept && is_io && cpu_we;
  assign we_next = accept ? cpu_we : we_reg;

  mmio_io_regs #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SW_W   (SW_W),
    .N_HEX  (N_HEX)
  ) u_io_regs (
    .clk        (Clk),
    .srst       (Reset),
    .wr         (io_wr),
    .ofs        (io_ofs),
    .wdata      (cpu_wdata),
    .switches   (switches),
    .rdata      (io_rdata),
    .hex_digits (hex_digits),
    .led        (led)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cpu_req) state_next = is_io ? RESP : SRAM;
      SRAM:    if (cnt_reg == '0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      oe_reg    <= 1'b0;
      wstb_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= cpu_addr;
        wdata_reg <= cpu_wdata;
        we_reg    <= cpu_we;
        cnt_reg   <= CNT_W'(SRAM_WAIT);
        // I/O reads complete on the accept edge, so the result is captured here.
        if (is_io && !cpu_we) rdata_reg <= io_rdata;
      end else if (state_reg == SRAM) begin
        if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end else if (!we_reg) begin
          rdata_reg <= sram_rdata;
        end
      end
      // Output flops are loaded from the next state so they line up with the state register.
      ready_reg <= (state_next == RESP);
      busy_reg  <= (state_next != IDLE);
      oe_reg    <= (state_next == SRAM) && !we_next;
      wstb_reg  <= (state_next == SRAM) && we_next;
    end
  end

  assign cpu_rdata  = rdata_reg;
  assign cpu_ready  = ready_reg;
  assign busy       = busy_reg;
  assign sram_addr  = addr_reg;
  assign sram_wdata = wdata_reg;
  assign sram_oe    = oe_reg;
  assign sram_we    = wstb_reg;

endmodule

// File: tb/tb_mmio_bridge.sv
// Scoreboard bench for mmio_bridge: a default build and a SRAM_WAIT=3 / N_HEX=2 build.
module tb_mmio_bridge;

  typedef struct {
    int          ready_cyc;
    logic        chk_rd;
    logic [15:0] rd;
    int          n_oe;
    int          n_we;
  } exp_t;

  logic clk, rst;
  logic [15:0] switches;

  logic        req0, we0, ready0, busy0, oe0, swe0;
  logic [15:0] addr0, wdata0, rdata0, saddr0, swdata0, srdata0, hex0, led0;
  logic        req1, we1, ready1, busy1, oe1, swe1;
  logic [15:0] addr1, wdata1, rdata1, saddr1, swdata1, srdata1, led1;
  logic [7:0]  hex1;

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  exp_t q0[$];
  exp_t q1[$];
  int oe_cnt[2];
  int we_cnt[2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  mmio_bridge dut0 (
    .Clk(clk), .Reset(rst), .cpu_req(req0), .cpu_we(we0), .cpu_addr(addr0),
    .cpu_wdata(wdata0), .cpu_rdata(rdata0), .cpu_ready(ready0), .busy(busy0),
    .sram_addr(saddr0), .sram_wdata(swdata0), .sram_rdata(srdata0),
    .sram_oe(oe0), .sram_we(swe0), .switches(switches), .hex_digits(hex0), .led(led0)
  );

  mmio_bridge #(.SRAM_WAIT(3), .N_HEX(2)) dut1 (
    .Clk(clk), .Reset(rst), .cpu_req(req1), .cpu_we(we1), .cpu_addr(addr1),
    .cpu_wdata(wdata1), .cpu_rdata(rdata1), .cpu_ready(ready1), .busy(busy1),
    .sram_addr(saddr1), .sram_wdata(swdata1), .sram_rdata(srdata1),
    .sram_oe(oe1), .sram_we(swe1), .switches(switches), .hex_digits(hex1), .led(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM models: remember writes, return stored data only while the read strobe is high.
  always @(posedge clk) begin
    if (swe0) mem0[saddr0[7:0]] <= swdata0;
    if (swe1) mem1[saddr1[7:0]] <= swdata1;
  end
  assign srdata0 = oe0 ? mem0[saddr0[7:0]] : 16'h0000;
  assign srdata1 = oe1 ? mem1[saddr1[7:0]] : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic rdy, input logic [15:0] rd,
                     input logic oe, input logic we);
    exp_t e;
    int   sz;
    if (oe) oe_cnt[d]++;
    if (we) we_cnt[d]++;
    if (oe || we) check($sformatf("dut%0d_single_strobe", d), 32'(oe & we), 32'd0);
    if (rdy) begin
      sz = (d == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        check($sformatf("dut%0d_spurious_ready", d), 32'(rdy), 32'd0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        $display("txn dut%0d: ready at cyc %0d (exp %0d) rdata=%h oe=%0d we=%0d",
                 d, cyc, e.ready_cyc, rd, oe_cnt[d], we_cnt[d]);
        check($sformatf("dut%0d_ready_cycle", d), 32'(cyc), 32'(e.ready_cyc));
        if (e.chk_rd) check($sformatf("dut%0d_rdata", d), 32'(rd), 32'(e.rd));
        check($sformatf("dut%0d_oe_cycles", d), 32'(oe_cnt[d]), 32'(e.n_oe));
        check($sformatf("dut%0d_we_cycles", d), 32'(we_cnt[d]), 32'(e.n_we));
      end
      oe_cnt[d] = 0;
      we_cnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      oe_cnt[0] = 0; we_cnt[0] = 0;
      oe_cnt[1] = 0; we_cnt[1] = 0;
    end else begin
      mon(0, ready0, rdata0, oe0, swe0);
      mon(1, ready1, rdata1, oe1, swe1);
    end
  end

  task automatic drive(input int d, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] wd);
    if (d == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = wd; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = wd; end
  endtask

  // lat = cycle number (after the accept edge) in which cpu_ready is expected.
  task automatic issue(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                       input int lat, input logic chk, input logic [15:0] exp_rd,
                       input int n_oe, input int n_we);
    exp_t e;
    bit   seen;
    @(negedge clk);
    drive(d, 1'b1, w, a, wd);
    @(posedge clk); #1;
    e.ready_cyc = cyc + lat - 1;
    e.chk_rd = chk; e.rd = exp_rd; e.n_oe = n_oe; e.n_we = n_we;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    drive(d, 1'b0, w, a, wd);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if ((d == 0) ? ready0 : ready1) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL dut%0d_timeout: no cpu_ready within 40 cycles, required one", d);
    end
  endtask

  initial begin
    exp_t e;
    int   c;
    rst = 1'b1; switches = 16'h0000;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_rdata", 32'(rdata0), 32'h0);
    check("rst_ready", 32'(ready0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_strobes", 32'({oe0, swe0, oe1, swe1}), 32'h0);
    check("rst_hex_led", 32'({hex0, led0}), 32'h0);
    check("rst_sram_lat", 32'({saddr0, swdata0}), 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);

    // SRAM write then read-back, default build (one wait state).
    issue(0, 1'b1, 16'h0040, 16'h1234, 3, 1'b0, 16'h0000, 0, 2);
    check("sram_wdata_hold", 32'(swdata0), 32'h1234);
    check("sram_addr_hold", 32'(saddr0), 32'h0040);
    issue(0, 1'b0, 16'h0040, 16'h0000, 3, 1'b1, 16'h1234, 2, 0);

    // I/O reads and writes.
    switches = 16'hA5A5;
    issue(0, 1'b0, 16'hFFFE, 16'h0000, 1, 1'b1, 16'hA5A5, 0, 0);
    issue(0, 1'b1, 16'hFFFE, 16'hBEEF, 1, 1'b0, 16'h0000, 0, 0);
    check("rdata_hold_after_write", 32'(rdata0), 32'hA5A5);
    issue(0, 1'b1, 16'hFFFF, 16'h00FF, 1, 1'b0, 16'h0000, 0, 0);
    check("hex_digits", 32'(hex0), 32'hBEEF);
    check("led", 32'(led0), 32'h00FF);
    issue(0, 1'b0, 16'hFFFF, 16'h0000, 1, 1'b1, 16'h00FF, 0, 0);

    // SRAM_WAIT=3, N_HEX=2 build.
    issue(1, 1'b1, 16'h0010, 16'h5A5A, 5, 1'b0, 16'h0000, 0, 4);
    issue(1, 1'b0, 16'h0010, 16'h0000, 5, 1'b1, 16'h5A5A, 4, 0);
    issue(1, 1'b1, 16'hFFFE, 16'hBEEF, 1, 1'b0, 16'h0000, 0, 0);
    check("hex_digits_nhex2", 32'(hex1), 32'h00EF);

    // cpu_req held high: second accept only after the IDLE cycle following ready.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'hFFFE, 16'h0000);
    @(posedge clk); #1;
    c = cyc;
    e.chk_rd = 1'b1; e.rd = 16'hA5A5; e.n_oe = 0; e.n_we = 0;
    e.ready_cyc = c;     q0.push_back(e);
    e.ready_cyc = c + 2; q0.push_back(e);
    repeat (3) @(negedge clk);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    check("held_req_idle", 32'(busy0), 32'h0);

    // Reset while a SRAM read is in progress aborts it with no ready.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    @(posedge clk); #1;
    check("abort_oe_cycle1", 32'(oe0), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_strobes", 32'({oe0, swe0}), 32'h0);
    check("abort_busy_ready", 32'({busy0, ready0}), 32'h0);
    check("abort_regs", 32'({hex0, led0}), 32'h0);
    check("abort_rdata", 32'(rdata0), 32'h0);
    req0 = 1'b0;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_idle", 32'(busy0), 32'h0);

    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
